// File: rtl/accum_buf_sched.sv
// Scheduler for the per-column accumulator FIFOs below the systolic array:
// skewed push/pop enables during fill, optional handshaked drain to writeback.
module accum_buf_sched #(
   parameter int unsigned COLS  = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] rows,
   input  logic             accumulate,
   input  logic             drain,
   input  logic             arr_valid,
   input  logic [COLS-1:0]  buf_full,
   input  logic [COLS-1:0]  buf_empty,
   output logic [COLS-1:0]  buf_wr_en,
   output logic [COLS-1:0]  buf_rd_en,
   output logic [COLS-1:0]  add_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {
      S_PRIME,
      S_IDLE,
      S_FILL,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] ROWS_MAX = CNT_W'(DEPTH);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] rows_q;
   logic [CNT_W-1:0] seen_q;
   logic [CNT_W-1:0] drained_q;
   logic             acc_q;
   logic             drain_q;
   logic             err_q;
   logic [COLS-1:0]  v_q;

   logic             accept;
   logic             drain_pop;
   logic             fill_err;
   logic             drain_err;

   // A row enters the skew only while the tile still has rows outstanding.
   assign accept    = (state == S_FILL) && arr_valid && (seen_q < rows_q);
   assign drain_pop = (state == S_DRAIN) && !buf_empty[0] && out_ready;
   assign fill_err  = (state == S_FILL) &&
                      (|((buf_wr_en & buf_full & ~buf_rd_en) | (buf_rd_en & buf_empty)));
   assign drain_err = (state == S_DRAIN) && (buf_empty != {COLS{buf_empty[0]}});
   assign err       = err_q;

   always_ff @(posedge clk) begin
      if (rst) state <= S_PRIME;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_PRIME: state_nx = S_IDLE;
         S_IDLE: begin
            if (start) state_nx = (rows == '0) ? S_DONE : S_FILL;
         end
         S_FILL: begin
            if ((seen_q == rows_q) && (v_q == '0)) state_nx = drain_q ? S_DRAIN : S_DONE;
         end
         S_DRAIN: begin
            if (drain_pop && (drained_q == rows_q - CNT_W'(1))) state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_PRIME;
      endcase
   end

   always_comb begin
      buf_wr_en = '0;
      buf_rd_en = '0;
      add_sel   = '0;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         // One blanket pop swallows the FIFOs' post-reset discard.
         S_PRIME: buf_rd_en = '1;
         S_FILL: begin
            buf_wr_en = v_q;
            buf_rd_en = v_q & {COLS{acc_q}};
            add_sel   = {COLS{acc_q}};
            busy      = 1'b1;
         end
         S_DRAIN: begin
            out_valid = !buf_empty[0];
            buf_rd_en = {COLS{drain_pop}};
            add_sel   = {COLS{acc_q}};
            busy      = 1'b1;
         end
         S_DONE: begin
            add_sel = {COLS{acc_q}};
            busy    = 1'b1;
            done    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rows_q    <= '0;
         seen_q    <= '0;
         drained_q <= '0;
         acc_q     <= 1'b0;
         drain_q   <= 1'b0;
         err_q     <= 1'b0;
         v_q       <= '0;
      end else begin
         v_q <= {v_q[COLS-2:0], accept};
         case (state)
            S_IDLE: begin
               if (start) begin
                  rows_q    <= (rows > ROWS_MAX) ? ROWS_MAX : rows;
                  acc_q     <= accumulate;
                  drain_q   <= drain;
                  err_q     <= (rows > ROWS_MAX);
                  seen_q    <= '0;
                  drained_q <= '0;
               end
            end
            S_FILL: begin
               if (accept)   seen_q <= seen_q + CNT_W'(1);
               if (fill_err) err_q  <= 1'b1;
            end
            S_DRAIN: begin
               if (drain_pop) drained_q <= drained_q + CNT_W'(1);
               if (drain_err) err_q     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_accum_buf_sched.sv
// Bench for accum_buf_sched: FIFO-row environment, timestamp-based reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_accum_buf_sched;

   localparam int COLS  = 8;
   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   localparam int P_PRIME = 0;
   localparam int P_IDLE  = 1;
   localparam int P_FILL  = 2;
   localparam int P_DRAIN = 3;
   localparam int P_DONE  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] rows = '0;
   logic             accumulate = 1'b0;
   logic             drain = 1'b0;
   logic             arr_valid = 1'b0;
   logic [COLS-1:0]  buf_full = '0;
   logic [COLS-1:0]  buf_empty = '1;
   logic [COLS-1:0]  buf_wr_en;
   logic [COLS-1:0]  buf_rd_en;
   logic [COLS-1:0]  add_sel;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             busy;
   logic             done;
   logic             err;

   int n_cmp = 0;
   int n_bad = 0;

   accum_buf_sched #(.COLS(COLS), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .rows(rows), .accumulate(accumulate),
      .drain(drain), .arr_valid(arr_valid), .buf_full(buf_full), .buf_empty(buf_empty),
      .buf_wr_en(buf_wr_en), .buf_rd_en(buf_rd_en), .add_sel(add_sel),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase, tile bookkeeping, column-0 acceptance timestamps, FIFO occupancy.
   int  cyc = 0;
   int  m_phase = P_PRIME;
   int  m_rows = 0, m_seen = 0, m_drained = 0;
   bit  m_acc = 0, m_drain = 0, m_err = 0;
   bit  mv = 0;
   int  acc_cyc[$];
   int  cnt[COLS];
   bit  disc[COLS];

   // Column c writes the row accepted at cycle k during cycle k+1+c.
   function automatic logic [COLS-1:0] exp_v();
      logic [COLS-1:0] v = '0;
      foreach (acc_cyc[i])
         for (int c = 0; c < COLS; c++)
            if (acc_cyc[i] + 1 + c == cyc) v[c] = 1'b1;
      return v;
   endfunction

   always @(negedge clk) begin
      logic [COLS-1:0] ev, ewr, erd, eadd, a_wr, a_rd;
      logic            eov, ebusy, edone;
      int              r;
      a_wr  = buf_wr_en;
      a_rd  = buf_rd_en;
      ev    = exp_v();
      ewr   = '0; erd = '0; eadd = '0; eov = 1'b0; ebusy = 1'b0; edone = 1'b0;
      case (m_phase)
         P_PRIME: erd = '1;
         P_FILL: begin
            ewr = ev; erd = m_acc ? ev : '0; eadd = {COLS{m_acc}}; ebusy = 1'b1;
         end
         P_DRAIN: begin
            eov = !buf_empty[0]; erd = (eov && out_ready) ? '1 : '0;
            eadd = {COLS{m_acc}}; ebusy = 1'b1;
         end
         P_DONE: begin
            eadd = {COLS{m_acc}}; ebusy = 1'b1; edone = 1'b1;
         end
         default: ;
      endcase
      if (mv) begin
         check("wr_en", a_wr, ewr);
         check("rd_en", a_rd, erd);
         check("add_sel", add_sel, eadd);
         check("out_valid", out_valid, eov);
         check("busy", busy, ebusy);
         check("done", done, edone);
         check("err", err, m_err);
      end
      if (rst) begin
         m_phase = P_PRIME; m_err = 0; m_acc = 0; m_drain = 0;
         m_rows = 0; m_seen = 0; m_drained = 0;
         acc_cyc.delete();
         for (int c = 0; c < COLS; c++) begin cnt[c] = 0; disc[c] = 1; end
         mv = 1;
      end else begin
         for (int c = 0; c < COLS; c++) begin
            bit pu, po;
            po = a_rd[c]; pu = a_wr[c];
            if (po && disc[c]) begin disc[c] = 0; po = 0; end
            if (po && cnt[c] == 0) po = 0;
            if (pu && cnt[c] >= DEPTH && !po) pu = 0;
            cnt[c] = cnt[c] + int'(pu) - int'(po);
         end
         case (m_phase)
            P_PRIME: m_phase = P_IDLE;
            P_IDLE: if (start) begin
               r = int'(rows);
               m_err = (r > DEPTH);
               if (r > DEPTH) r = DEPTH;
               m_rows = r; m_acc = accumulate; m_drain = drain;
               m_seen = 0; m_drained = 0; acc_cyc.delete();
               m_phase = (r == 0) ? P_DONE : P_FILL;
            end
            P_FILL: begin
               for (int c = 0; c < COLS; c++) begin
                  if (ev[c] && buf_full[c] && !m_acc) m_err = 1;
                  if (ev[c] && m_acc && buf_empty[c]) m_err = 1;
               end
               if (m_seen == m_rows && ev == '0) m_phase = m_drain ? P_DRAIN : P_DONE;
               else if (arr_valid && m_seen < m_rows) begin
                  acc_cyc.push_back(cyc); m_seen++;
               end
            end
            P_DRAIN: begin
               if (buf_empty != {COLS{buf_empty[0]}}) m_err = 1;
               if (eov && out_ready) begin
                  m_drained++;
                  if (m_drained == m_rows) m_phase = P_DONE;
               end
            end
            P_DONE: m_phase = P_IDLE;
            default: m_phase = P_PRIME;
         endcase
      end
      cyc++;
   end

   // FIFO status flags follow the occupancy model, updated just after each edge.
   always @(posedge clk) begin
      #1;
      for (int c = 0; c < COLS; c++) begin
         buf_full[c]  = (cnt[c] >= DEPTH);
         buf_empty[c] = (cnt[c] == 0);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (m_phase != P_IDLE && k < 400) begin tick(); k++; end
      check("idle_wait", (m_phase == P_IDLE), 1);
   endtask

   task automatic do_start(input int r, input bit a, input bit d);
      start = 1'b1; rows = CNT_W'(r); accumulate = a; drain = d;
      tick();
      start = 1'b0; rows = CNT_W'($urandom); accumulate = 1'($urandom); drain = 1'($urandom);
   endtask

   logic [COLS-1:0] wr_h[16];
   logic            dn_h[16];
   logic [COLS-1:0] rd_or, add_h;
   logic [5:0]      pat = 6'b101101;
   int              mirror_bad, pops, bad_pops, stall_drop, done_n, done_after, w0, ph, k;

   initial begin
      #1ms;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("prime_rd_en", buf_rd_en, 8'hFF);
      check("prime_busy", busy, 0);
      tick();
      @(negedge clk);
      check("idle_rd_en", buf_rd_en, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      tick();

      // Tile 1: overwrite, 4 contiguous rows.
      wait_idle();
      do_start(4, 0, 0);
      arr_valid = 1'b1; rd_or = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         wr_h[i] = buf_wr_en; dn_h[i] = done; rd_or |= buf_rd_en;
         tick();
         arr_valid = (i < 3);
      end
      check("t1_wr_f0", wr_h[0], 8'h00);
      check("t1_wr_f1", wr_h[1], 8'h01);
      check("t1_wr_f4", wr_h[4], 8'h0F);
      check("t1_wr_f5", wr_h[5], 8'h1E);
      check("t1_wr_f11", wr_h[11], 8'h80);
      check("t1_wr_f12", wr_h[12], 8'h00);
      check("t1_done_f12", dn_h[12], 0);
      check("t1_done_f13", dn_h[13], 1);
      check("t1_rd_none", rd_or, 0);
      check("t1_err", err, 0);

      // Tile 2: accumulate over the same 4 rows.
      wait_idle();
      do_start(4, 1, 0);
      arr_valid = 1'b1; mirror_bad = 0; add_h = '0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (buf_rd_en != buf_wr_en) mirror_bad++;
         if (i == 2) add_h = add_sel;
         tick();
         arr_valid = (i < 3);
      end
      wait_idle();
      check("t2_add_sel", add_h, 8'hFF);
      check("t2_mirror", mirror_bad, 0);
      check("t2_occ_c0", cnt[0], 4);
      check("t2_occ_c7", cnt[7], 4);
      check("t2_err", err, 0);

      // Tile 3: overwrite then drain with a stalling writeback.
      do_start(4, 0, 1);
      k = 0; pops = 0; bad_pops = 0; stall_drop = 0; done_n = 0; done_after = -1;
      for (int i = 0; i < 40; i++) begin
         ph = m_phase;
         if (ph == P_DRAIN) begin out_ready = pat[k % 6]; k++; end
         else out_ready = 1'b0;
         arr_valid = (i < 4);
         @(negedge clk);
         if (buf_rd_en == '1 && ph == P_DRAIN) begin
            pops++;
            if (!out_ready) bad_pops++;
         end
         if (ph == P_DRAIN && !out_ready && !out_valid) stall_drop++;
         if (done) begin done_n++; done_after = pops; end
         tick();
      end
      out_ready = 1'b0;
      check("t3_pops", pops, 4);
      check("t3_pops_unready", bad_pops, 0);
      check("t3_valid_hold", stall_drop, 0);
      check("t3_done_count", done_n, 1);
      check("t3_done_after", done_after, 4);
      check("t3_occ_c0", cnt[0], 4);

      // Tile 4: oversized row count clamps to DEPTH.
      wait_idle();
      do_start(12, 0, 0);
      w0 = 0;
      for (int i = 0; i < 30; i++) begin
         arr_valid = (i < 12);
         @(negedge clk);
         if (buf_wr_en[0]) w0++;
         tick();
      end
      check("t4_col0_writes", w0, 8);
      check("t4_err", err, 1);

      rst = 1'b1; tick(); tick(); rst = 1'b0;
      @(negedge clk);
      check("rst_rd_en", buf_rd_en, 8'hFF);
      check("rst_err", err, 0);
      tick();

      // Tile 5: surplus arr_valid beyond the row count is ignored.
      wait_idle();
      do_start(4, 0, 0);
      w0 = 0;
      for (int i = 0; i < 20; i++) begin
         arr_valid = (i < 7);
         @(negedge clk);
         if (buf_wr_en[0]) w0++;
         tick();
      end
      check("t5_col0_writes", w0, 4);
      check("t5_err", err, 0);

      // Tile 6: reset mid-fill after two column-0 writes, then a clean drain tile.
      wait_idle();
      do_start(4, 0, 0);
      arr_valid = 1'b1; tick(); tick();
      arr_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("t6_second_write", buf_wr_en[0], 1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6_prime_rd", buf_rd_en, 8'hFF);
      check("t6_prime_wr", buf_wr_en, 0);
      check("t6_prime_busy", busy, 0);
      check("t6_prime_ov", out_valid, 0);
      tick();
      wait_idle();
      do_start(4, 0, 1);
      pops = 0; done_n = 0;
      for (int i = 0; i < 30; i++) begin
         ph = m_phase;
         arr_valid = (i < 4); out_ready = 1'b1;
         @(negedge clk);
         if (buf_rd_en == '1 && ph == P_DRAIN) pops++;
         if (done) done_n++;
         tick();
      end
      out_ready = 1'b0;
      check("t6_pops", pops, 4);
      check("t6_done_count", done_n, 1);
      check("t6_err", err, 0);

      // Randomized tiles, including stray starts, surplus rows and occasional reset.
      for (int t = 0; t < 40; t++) begin
         int r;
         bit a, d;
         wait_idle();
         r = int'($urandom_range(0, 10));
         a = 1'($urandom_range(0, 1));
         d = !a && ($urandom_range(0, 1) == 1);
         do_start(r, a, d);
         k = 0;
         while (m_phase != P_IDLE && k < 300) begin
            arr_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            start     = ($urandom_range(0, 9) == 0);
            rows      = CNT_W'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
            k++;
         end
         start = 1'b0; rst = 1'b0;
         check("rand_tile_end", (m_phase == P_IDLE), 1);
      end
      arr_valid = 1'b0; out_ready = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
